axi_lite_ic_1xn: RTL and testbench

- Parametrised AXI4-Lite 1-to-N interconnect. One CPU-side master port fans out to NUM_SLAVES slave ports.
- Each slave is selected by an (addr & MASK) == (BASE & MASK) decode.
- Adds over the 1x2 generation:
  - BRESP/RRESP passthrough.
  - Internal DECERR responder for unmapped addresses.
  - Decode-error event pulses and a saturating error counter.
- Sits between the core's AXI-Lite master and the memory/peripheral sub-buses; may cascade under another instance.

---
 rtl/axi_lite_pkg.sv | 11 +
 rtl/axi_lite_addr_dec.sv | 21 ++
 rtl/axi_lite_ic_1xn.sv | 175 +++++++++++++++++
 tb/tb_axi_lite_ic_1xn.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, FSM encodings and address-decode helper for the AXI-Lite interconnect
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
  function automatic logic addr_hit(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] mask);
    return (addr & mask) == (base & mask);
  endfunction
endpackage

// File: rtl/axi_lite_addr_dec.sv
// axi_lite_addr_dec: base/mask decode to a one-hot select, lowest index wins on overlap
module axi_lite_addr_dec import axi_lite_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  miss
);
  logic [NUM_SLAVES-1:0] hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      hit[i] = addr_hit(64'(addr), 64'(SLV_BASE[i*ADDR_W +: ADDR_W]), 64'(SLV_MASK[i*ADDR_W +: ADDR_W]));
  end
  // isolate the lowest set bit
  assign sel  = hit & (~hit + 1'b1);
  assign miss = ~|hit;
endmodule

// File: rtl/axi_lite_ic_1xn.sv
// axi_lite_ic_1xn: AXI4-Lite 1-to-N interconnect with DECERR responder and decode-error counter
module axi_lite_ic_1xn import axi_lite_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter logic [31:0] DECERR_DATA = 32'hDEAD_BEEF,
  parameter int ERRCNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_awvalid,
  output logic                         m_awready,
  input  logic [ADDR_W-1:0]            m_awaddr,
  input  logic [2:0]                   m_awprot,
  input  logic                         m_wvalid,
  output logic                         m_wready,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_bvalid,
  input  logic                         m_bready,
  output logic [1:0]                   m_bresp,
  input  logic                         m_arvalid,
  output logic                         m_arready,
  input  logic [ADDR_W-1:0]            m_araddr,
  input  logic [2:0]                   m_arprot,
  output logic                         m_rvalid,
  input  logic                         m_rready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [1:0]                   m_rresp,
  output logic [NUM_SLAVES-1:0]        s_awvalid,
  input  logic [NUM_SLAVES-1:0]        s_awready,
  output logic [ADDR_W-1:0]            s_awaddr,
  output logic [2:0]                   s_awprot,
  output logic [NUM_SLAVES-1:0]        s_wvalid,
  input  logic [NUM_SLAVES-1:0]        s_wready,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_bvalid,
  output logic [NUM_SLAVES-1:0]        s_bready,
  input  logic [2*NUM_SLAVES-1:0]      s_bresp,
  output logic [NUM_SLAVES-1:0]        s_arvalid,
  input  logic [NUM_SLAVES-1:0]        s_arready,
  output logic [ADDR_W-1:0]            s_araddr,
  output logic [2:0]                   s_arprot,
  input  logic [NUM_SLAVES-1:0]        s_rvalid,
  output logic [NUM_SLAVES-1:0]        s_rready,
  input  logic [DATA_W*NUM_SLAVES-1:0] s_rdata,
  input  logic [2*NUM_SLAVES-1:0]      s_rresp,
  output logic                         wr_decerr,
  output logic                         rd_decerr,
  output logic [ERRCNT_W-1:0]          decerr_cnt,
  input  logic                         decerr_clr
);
  localparam int CW = ERRCNT_W + 1;
  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [NUM_SLAVES-1:0] wsel_q, wsel_d, rsel_q, rsel_d, aw_sel, ar_sel;
  logic wmiss_q, wmiss_d, rmiss_q, rmiss_d, aw_miss, ar_miss;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_sum;
  logic wr_idle, wr_data, wr_resp, rd_idle, rd_resp;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [1:0] bresp_mux, rresp_mux;
  logic [DATA_W-1:0] rdata_mux;

  axi_lite_addr_dec #(.NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_aw_dec (.addr(m_awaddr), .sel(aw_sel), .miss(aw_miss));
  axi_lite_addr_dec #(.NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_ar_dec (.addr(m_araddr), .sel(ar_sel), .miss(ar_miss));

  assign s_awaddr = m_awaddr;
  assign s_awprot = m_awprot;
  assign s_wdata  = m_wdata;
  assign s_wstrb  = m_wstrb;
  assign s_araddr = m_araddr;
  assign s_arprot = m_arprot;

  // master-facing handshakes are held low while reset is asserted
  assign wr_idle = !rst && wr_state_q == WR_IDLE;
  assign wr_data = !rst && wr_state_q == WR_DATA;
  assign wr_resp = !rst && wr_state_q == WR_RESP;
  assign rd_idle = !rst && rd_state_q == RD_IDLE;
  assign rd_resp = !rst && rd_state_q == RD_RESP;

  always_comb begin
    bresp_mux = '0;
    rresp_mux = '0;
    rdata_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bresp_mux |= wsel_q[i] ? s_bresp[2*i +: 2] : 2'b00;
      rresp_mux |= rsel_q[i] ? s_rresp[2*i +: 2] : 2'b00;
      rdata_mux |= rsel_q[i] ? s_rdata[DATA_W*i +: DATA_W] : '0;
    end
  end

  always_comb begin
    m_awready = wr_idle && (aw_miss || |(aw_sel & s_awready));
    s_awvalid = (wr_idle && m_awvalid) ? aw_sel : '0;
    m_wready  = wr_data && (wmiss_q || |(wsel_q & s_wready));
    s_wvalid  = (wr_data && m_wvalid) ? wsel_q : '0;
    m_bvalid  = wr_resp && (wmiss_q || |(wsel_q & s_bvalid));
    m_bresp   = !wr_resp ? 2'b00 : wmiss_q ? RESP_DECERR : bresp_mux;
    s_bready  = (wr_resp && m_bready) ? wsel_q : '0;
    wr_decerr = m_awvalid && m_awready && aw_miss;
  end

  always_comb begin
    m_arready = rd_idle && (ar_miss || |(ar_sel & s_arready));
    s_arvalid = (rd_idle && m_arvalid) ? ar_sel : '0;
    m_rvalid  = rd_resp && (rmiss_q || |(rsel_q & s_rvalid));
    m_rdata   = !rd_resp ? '0 : rmiss_q ? DATA_W'(DECERR_DATA) : rdata_mux;
    m_rresp   = !rd_resp ? 2'b00 : rmiss_q ? RESP_DECERR : rresp_mux;
    s_rready  = (rd_resp && m_rready) ? rsel_q : '0;
    rd_decerr = m_arvalid && m_arready && ar_miss;
  end

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid && m_rready;

  always_comb begin
    wr_state_d = wr_state_q;
    wsel_d     = wsel_q;
    wmiss_d    = wmiss_q;
    if (aw_hs) begin
      wr_state_d = WR_DATA;
      wsel_d     = aw_sel;
      wmiss_d    = aw_miss;
    end else if (w_hs) wr_state_d = WR_RESP;
    else if (b_hs) wr_state_d = WR_IDLE;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rsel_d     = rsel_q;
    rmiss_d    = rmiss_q;
    if (ar_hs) begin
      rd_state_d = RD_RESP;
      rsel_d     = ar_sel;
      rmiss_d    = ar_miss;
    end else if (r_hs) rd_state_d = RD_IDLE;
  end

  // saturating add; clear wins over a same-cycle increment
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + CW'(wr_decerr) + CW'(rd_decerr);
    cnt_d   = decerr_clr ? '0 : cnt_sum[ERRCNT_W] ? '1 : cnt_sum[ERRCNT_W-1:0];
  end

  assign decerr_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wsel_q     <= '0;
      rsel_q     <= '0;
      wmiss_q    <= 1'b0;
      rmiss_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      wmiss_q    <= wmiss_d;
      rmiss_q    <= rmiss_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_ic_1xn.sv
// tb_axi_lite_ic_1xn: directed scoreboard bench for the 1xN AXI-Lite interconnect
module tb_axi_lite_ic_1xn;
  import axi_lite_pkg::*;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  logic m_awvalid = 0, m_awready, m_wvalid = 0, m_wready, m_bvalid, m_bready = 0;
  logic m_arvalid = 0, m_arready, m_rvalid, m_rready = 0;
  logic [AW-1:0] m_awaddr = '0, m_araddr = '0, s_awaddr, s_araddr;
  logic [2:0] m_awprot = '0, m_arprot = '0, s_awprot, s_arprot;
  logic [DW-1:0] m_wdata = '0, m_rdata, s_wdata;
  logic [DW/8-1:0] m_wstrb = '0, s_wstrb;
  logic [1:0] m_bresp, m_rresp;
  logic [N-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [2*N-1:0] s_bresp, s_rresp;
  logic [DW*N-1:0] s_rdata;
  logic wr_decerr, rd_decerr, decerr_clr = 0;
  logic [CW-1:0] decerr_cnt;
  int n_chk = 0, n_fail = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];

  axi_lite_ic_1xn #(
    .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE({32'h0000_0000, 32'h4000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .DECERR_DATA(32'hDEAD_BEEF), .ERRCNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .wr_decerr(wr_decerr), .rd_decerr(rd_decerr), .decerr_cnt(decerr_cnt), .decerr_clr(decerr_clr)
  );

  always #5 clk = ~clk;

  // slave models: always ready, B one cycle after W, read data = addr ^ 0x5A5A5A5A, slave 1 answers SLVERR
  logic [N-1:0] bpend, rpend;
  logic [DW-1:0] rdat [N];
  assign s_awready = '1;
  assign s_wready  = '1;
  assign s_arready = '1;
  assign s_bvalid  = bpend;
  assign s_rvalid  = rpend;
  assign s_bresp   = 8'b00_00_10_00;
  assign s_rresp   = 8'b00_00_10_00;
  always_comb for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = rdat[i];
  always @(posedge clk) begin
    if (rst) begin
      bpend <= '0;
      rpend <= '0;
    end else for (int i = 0; i < N; i++) begin
      if (s_wvalid[i] && s_wready[i]) bpend[i] <= 1'b1;
      else if (s_bvalid[i] && s_bready[i]) bpend[i] <= 1'b0;
      if (s_arvalid[i] && s_arready[i]) begin
        rpend[i] <= 1'b1;
        rdat[i]  <= s_araddr ^ 32'h5A5A_5A5A;
      end else if (s_rvalid[i] && s_rready[i]) rpend[i] <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever a response handshake is presented
  always @(negedge clk) begin
    if (!rst && m_bvalid && m_bready) begin
      if (bq.size() == 0) check("b_unexpected", 64'(1), 64'(0));
      else check("bresp", 64'(m_bresp), 64'(bq.pop_front()));
    end
    if (!rst && m_rvalid && m_rready) begin
      if (rq.size() == 0) check("r_unexpected", 64'(1), 64'(0));
      else check("rdata_rresp", 64'({m_rdata, m_rresp}), 64'(rq.pop_front()));
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] onehot,
                          input logic [1:0] exp_bresp, input bit early_w);
    if (early_w) begin
      m_wvalid = 1; m_wdata = data;
      repeat (2) begin @(negedge clk); check("w_before_aw", 64'(m_wready), 64'(0)); end
      @(posedge clk); #1;
    end
    bq.push_back(exp_bresp);
    m_awvalid = 1; m_awaddr = addr; m_bready = 1;
    @(negedge clk);
    for (int k = 0; k < 20 && !m_awready; k++) @(negedge clk);
    check("aw_accept", 64'(m_awready), 64'(1));
    check("s_awvalid", 64'(s_awvalid), 64'(onehot));
    check("wr_decerr", 64'(wr_decerr), 64'(onehot == 0));
    @(posedge clk); #1;
    m_awvalid = 0; m_wvalid = 1; m_wdata = data; m_wstrb = '1;
    @(negedge clk);
    for (int k = 0; k < 20 && !m_wready; k++) @(negedge clk);
    check("w_accept", 64'(m_wready), 64'(1));
    check("s_wvalid", 64'(s_wvalid), 64'(onehot));
    check("s_wdata", 64'(s_wdata), 64'(data));
    @(posedge clk); #1;
    m_wvalid = 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !m_bvalid; k++) @(negedge clk);
    check("b_arrive", 64'(m_bvalid), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] onehot, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input bit stall);
    rq.push_back({exp_data, exp_resp});
    m_arvalid = 1; m_araddr = addr; m_rready = 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !m_arready; k++) @(negedge clk);
    check("ar_accept", 64'(m_arready), 64'(1));
    check("s_arvalid", 64'(s_arvalid), 64'(onehot));
    check("rd_decerr", 64'(rd_decerr), 64'(onehot == 0));
    @(posedge clk); #1;
    m_arvalid = 0; m_rready = !stall;
    if (stall) begin
      repeat (3) begin
        @(negedge clk);
        check("stall_rvalid", 64'(m_rvalid), 64'(1));
        check("stall_rdata", 64'(m_rdata), 64'(exp_data));
        check("stall_state", 64'(dut.rd_state_q), 64'(RD_RESP));
      end
      @(posedge clk); #1;
      m_rready = 1;
    end
    @(negedge clk);
    for (int k = 0; k < 20 && !(m_rvalid && m_rready); k++) @(negedge clk);
    check("r_arrive", 64'(m_rvalid), 64'(1));
    @(posedge clk); #1;
    m_rready = 0;
  endtask

  task automatic both_miss(input bit clr, input logic [CW-1:0] exp_cnt);
    bq.push_back(RESP_DECERR);
    rq.push_back({32'hDEAD_BEEF, RESP_DECERR});
    m_awvalid = 1; m_awaddr = 32'hF000_0000; m_arvalid = 1; m_araddr = 32'h8000_0000;
    m_bready = 1; m_rready = 1; decerr_clr = clr;
    @(negedge clk);
    check("both_ready", 64'({m_awready, m_arready}), 64'(2'b11));
    check("both_pulse", 64'({wr_decerr, rd_decerr}), 64'(2'b11));
    @(posedge clk); #1;
    m_awvalid = 0; m_arvalid = 0; decerr_clr = 0; m_wvalid = 1;
    @(posedge clk); #1;
    m_wvalid = 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !m_bvalid; k++) @(negedge clk);
    check("miss_b_arrive", 64'(m_bvalid), 64'(1));
    check("decerr_cnt", 64'(decerr_cnt), 64'(exp_cnt));
    @(posedge clk); #1;
    m_rready = 0;
  endtask

  logic [CW-1:0] sat_tbl [7] = '{4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd15};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 64'({m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_bresp, m_rresp}), 64'(0));
    check("rst_cnt", 64'(decerr_cnt), 64'(0));
    @(posedge clk); #1;
    rst = 0;
    do_write(32'h4000_0010, 32'h1234_5678, 4'b0100, RESP_OKAY, 0);
    do_read(32'hF000_0000, 4'b0000, 32'hDEAD_BEEF, RESP_DECERR, 0);
    @(negedge clk);
    check("rd_decerr_once", 64'(rd_decerr), 64'(0));
    check("cnt_after_rd_miss", 64'(decerr_cnt), 64'(1));
    @(posedge clk); #1;
    do_read(32'h1000_0020, 4'b0010, 32'h4A5A_5A7A, RESP_SLVERR, 1);
    @(negedge clk);
    check("rd_idle_after_hs", 64'(dut.rd_state_q), 64'(RD_IDLE));
    @(posedge clk); #1;
    do_write(32'h1000_0004, 32'hCAFE_0001, 4'b0010, RESP_SLVERR, 0);
    do_write(32'h0000_0100, 32'hA5A5_0F0F, 4'b0001, RESP_OKAY, 1);
    do_read(32'h00AB_0000, 4'b0001, 32'h5AF1_5A5A, RESP_OKAY, 0);
    both_miss(0, 4'd3);
    foreach (sat_tbl[i]) both_miss(0, sat_tbl[i]);
    both_miss(1, 4'd0);
    do_read(32'hF000_0000, 4'b0000, 32'hDEAD_BEEF, RESP_DECERR, 0);
    decerr_clr = 1;
    @(posedge clk); #1;
    decerr_clr = 0;
    @(negedge clk);
    check("cnt_cleared", 64'(decerr_cnt), 64'(0));
    @(posedge clk); #1;
    // abandon a write in WR_DATA with reset
    m_awvalid = 1; m_awaddr = 32'h0000_0200;
    @(negedge clk);
    check("rst_aw_accept", 64'(m_awready), 64'(1));
    @(posedge clk); #1;
    m_awvalid = 0;
    @(negedge clk);
    check("in_wr_data", 64'(dut.wr_state_q), 64'(WR_DATA));
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("mid_rst_outputs", 64'({m_awready, m_wready, m_bvalid, m_arready, m_rvalid}), 64'(0));
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_state", 64'({dut.wr_state_q, dut.rd_state_q}), 64'({WR_IDLE, RD_IDLE}));
    check("post_rst_wready", 64'({m_wready, m_bvalid, m_rvalid}), 64'(0));
    @(posedge clk); #1;
    do_write(32'h4000_0040, 32'h0BAD_F00D, 4'b0100, RESP_OKAY, 0);
    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'({bq.size() == 0, rq.size() == 0}), 64'(2'b11));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
